fpalu_add_wb: RTL and testbench
===============================

Name: fpalu_add_wb

Overview:
- Writeback/result stage directly downstream of the single-precision FP adder.
- Captures each 32-bit adder sum into a small FIFO with a valid/ready handshake, so the adder output can be held while the consumer stalls.
- Classifies every result (NaN, infinity, zero, sign) as it is pushed.
- Keeps sticky exception flags for software/status readout.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CW, 3, width of the occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  adder result on in_sum is valid this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_sum  input  32  IEEE-754 single result from the adder: sign[31], exp[30:23], frac[22:0].
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head entry this cycle.
- out_data  output  32  head entry result word.
- out_flags  output  4  head entry class: {nan, inf, zero, neg}.
- flag_clr  input  1  clear sticky flags.
- sticky_flags  output  3  accumulated {nan, inf, zero} since last clear/reset.
- count  output  CW  number of occupied entries, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset: count=0, read/write pointers=0, out_valid=0, out_data=0, out_flags=0, sticky_flags=0, in_ready=1 in the cycle after reset deasserts. rst asserted mid-operation discards all entries and ignores any push, pop or flag_clr in that cycle.
- Push: occurs when in_valid && in_ready. Stores in_sum plus its class bits at the write pointer; write pointer increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. Read pointer increments modulo DEPTH.
- in_ready = (count != DEPTH). It is derived from registered count only; there is no combinational path from out_ready.
- out_valid = (count != 0).
- out_data/out_flags show the head entry. Both are forced to 0 when count==0.
- Latency: a push into an empty FIFO appears on out_valid/out_data on the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop, 0<count<DEPTH: both occur, count unchanged, ordering preserved.
- count==DEPTH: no push (in_ready=0); pop allowed.
- count==0: no pop (out_valid=0); push allowed.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- Classification, computed combinationally on in_sum and stored with the entry:
  - nan = exp==8'hFF && frac!=0
  - inf = exp==8'hFF && frac==0
  - zero = exp==0 && frac==0
  - neg = bit31, kept for all classes including NaN and zero
  - At most one of nan/inf/zero is set.
- Sticky flags update on push only: sticky <= (flag_clr ? 0 : sticky) | pushed_class[3:1].
  - flag_clr in the same cycle as a push therefore leaves only the new entry's flags set.
  - flag_clr with no push clears to 0.
- Data is never modified except under the optional feature.

Optional Feature:
- Macro: FPALU_WB_CANON_NAN_EN.
- When defined: any pushed NaN is stored as canonical 32'h7FC00000; the nan flag stays set and neg is forced to 0.
- When undefined: NaN payload and sign are passed through unchanged.
- Classification and sticky behaviour are identical in both builds.

Test Plan:
- Reset then idle -> count=0, out_valid=0, out_data=0, in_ready=1, sticky_flags=0.
- Push 32'h3F800000 at empty with out_ready=1 -> out_valid next cycle, out_data=32'h3F800000, out_flags=4'b0000, count 1 then 0 after pop.
- DEPTH=4: push 5 values with out_ready=0 -> in_ready=0 after 4th, 5th not accepted, count=4; then drain -> same 4 values in order, wrap verified on refill.
- Push 32'hFF800000, then 32'h80000000 -> out_flags 4'b0101 then 4'b0011, sticky_flags=3'b011.
- Push 32'h7F800001 with flag_clr same cycle, sticky previously 3'b010 -> sticky_flags=3'b100; out_data=32'h7F800001 without macro, 32'h7FC00000 with FPALU_WB_CANON_NAN_EN.
- Count=2, simultaneous push/pop every cycle for 10 cycles, then rst asserted mid-stream -> count stays 2 throughout, order preserved; after rst, count=0 and out_valid=0.

Source files
------------

// File: rtl/fpalu_add_wb.sv
// Writeback stage behind the FP adder: buffers sums, classifies them, keeps sticky exception flags.
// Latency: 1 cycle from a push into an empty FIFO to out_valid/out_data (no bypass).
// Backpressure: in_ready drops when DEPTH entries are held; it depends on registered count only.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/in_ready adder result handshake, in_sum carries the IEEE-754 single word
//   out_valid/out_ready consumer handshake, out_data/out_flags show the head entry
//   out_flags         {nan, inf, zero, neg} of the head entry
//   flag_clr          clears sticky_flags ({nan, inf, zero} seen since last clear/reset)
//   count             occupied entries, 0..DEPTH
//
// Build option: define FPALU_WB_CANON_NAN_EN to store every pushed NaN as the
// canonical quiet NaN 32'h7FC00000 (neg forced to 0). Without it the NaN payload
// and sign pass through untouched. Classification and sticky flags are the same
// in both builds.
//
// DEPTH must be a power of two (>= 2) and CW must be log2(DEPTH)+1 so that the
// pointers wrap naturally and count can hold the value DEPTH.

module fpalu_add_wb #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_sum,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [3:0]    out_flags,
  input  logic          flag_clr,
  output logic [2:0]    sticky_flags,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // One FIFO entry: class bits travel with the result word.
  typedef struct packed {
    logic        nan;
    logic        inf;
    logic        zero;
    logic        neg;
    logic [31:0] dat;
  } wb_entry_t;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic push;
  logic pop;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid  && in_ready;
  assign pop       = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Classification of the incoming sum
  // ---------------------------------------------------------------------------
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        is_nan;
  logic        is_inf;
  logic        is_zero;
  wb_entry_t   wr_entry;

  assign in_exp  = in_sum[30:23];
  assign in_frac = in_sum[22:0];

  // exp==FF splits on frac into NaN/inf; exp==0 with frac==0 is zero.
  // Denormals (exp==0, frac!=0) fall into none of the three classes.
  assign is_nan  = (in_exp == 8'hFF) && (in_frac != '0);
  assign is_inf  = (in_exp == 8'hFF) && (in_frac == '0);
  assign is_zero = (in_exp == 8'h00) && (in_frac == '0);

  always_comb begin
    wr_entry      = '0;
    wr_entry.nan  = is_nan;
    wr_entry.inf  = is_inf;
    wr_entry.zero = is_zero;
`ifdef FPALU_WB_CANON_NAN_EN
    // Canonicalise so downstream never sees payload or sign on a NaN.
    wr_entry.neg  = is_nan ? 1'b0 : in_sum[31];
    wr_entry.dat  = is_nan ? 32'h7FC0_0000 : in_sum;
`else
    wr_entry.neg  = in_sum[31];
    wr_entry.dat  = in_sum;
`endif
  end

  // ---------------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------------
  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  wb_entry_t       head;

  // Storage is not reset: out_data/out_flags are masked while empty, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Power-of-two DEPTH lets the pointers wrap DEPTH-1 -> 0 by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_data  = out_valid ? head.dat : 32'h0;
  assign out_flags = out_valid ? {head.nan, head.inf, head.zero, head.neg} : 4'h0;

  // ---------------------------------------------------------------------------
  // Sticky exception flags {nan, inf, zero}
  // ---------------------------------------------------------------------------
  // A clear coinciding with a push keeps the new entry's class: clear first,
  // then OR in what is being pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (push) begin
      sticky_flags <= (flag_clr ? 3'b000 : sticky_flags) |
                      {wr_entry.nan, wr_entry.inf, wr_entry.zero};
    end else if (flag_clr) begin
      sticky_flags <= '0;
    end
  end

endmodule

// File: tb/tb_fpalu_add_wb.sv
// Directed testbench for fpalu_add_wb (DEPTH=4): reset, handshake, full/empty,
// pointer wrap, classification, sticky flags, streaming and mid-stream reset.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_fpalu_add_wb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic        flag_clr;
  logic [2:0]  sticky_flags;
  logic [2:0]  count;

  int n_checks;
  int n_errors;

`ifdef FPALU_WB_CANON_NAN_EN
  localparam logic [31:0] NAN1_EXP = 32'h7FC0_0000;
  localparam logic [31:0] NAN2_EXP = 32'h7FC0_0000;
  localparam logic [3:0]  NAN2_FLG = 4'b1000;
`else
  localparam logic [31:0] NAN1_EXP = 32'h7F80_0001;
  localparam logic [31:0] NAN2_EXP = 32'hFFC0_0001;
  localparam logic [3:0]  NAN2_FLG = 4'b1001;
`endif

  fpalu_add_wb #(
    .DEPTH (4),
    .CW    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sum       (in_sum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fill_vals [5];
  logic [31:0] q [$];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = 32'h0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    fill_vals[0] = 32'h4000_0000;
    fill_vals[1] = 32'h4040_0000;
    fill_vals[2] = 32'hC080_0000;
    fill_vals[3] = 32'h40A0_0000;
    fill_vals[4] = 32'h40C0_0000;

    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_count",     32'(count),        32'd0);
    chk("rst_out_valid", 32'(out_valid),    32'd0);
    chk("rst_out_data",  out_data,          32'h0);
    chk("rst_out_flags", 32'(out_flags),    32'd0);
    chk("rst_in_ready",  32'(in_ready),     32'd1);
    chk("rst_sticky",    32'(sticky_flags), 32'd0);

    // Single push into empty FIFO, consumer ready
    in_valid  = 1'b1;
    in_sum    = 32'h3F80_0000;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_data",  out_data,       32'h3F80_0000);
    chk("one_flags", 32'(out_flags), 32'd0);
    chk("one_count", 32'(count),     32'd1);
    tick();
    chk("one_count_after_pop", 32'(count),     32'd0);
    chk("one_valid_after_pop", 32'(out_valid), 32'd0);
    chk("one_data_after_pop",  out_data,       32'h0);
    out_ready = 1'b0;

    // Fill with 5 pushes; pointers start at 1 so the write side wraps
    for (int i = 0; i < 5; i++) begin
      chk("fill_in_ready", 32'(in_ready), 32'(i < 4));
      in_valid = 1'b1;
      in_sum   = fill_vals[i];
      tick();
    end
    in_valid = 1'b0;
    chk("full_count",    32'(count),    32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_flags",    32'(out_flags), 32'd0);

    // Drain: first four values in order, fifth never stored
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data",  out_data,       fill_vals[i]);
      tick();
    end
    chk("drain_count", 32'(count),     32'd0);
    chk("drain_valid_end", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Refill across the wrap point
    in_valid = 1'b1;
    in_sum   = 32'h4120_0000;
    tick();
    in_sum   = 32'hC1A0_0000;
    tick();
    in_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd2);
    out_ready = 1'b1;
    chk("refill_data0",  out_data,       32'h4120_0000);
    tick();
    chk("refill_data1",  out_data,       32'hC1A0_0000);
    chk("refill_flags1", 32'(out_flags), 32'b0001);
    tick();
    out_ready = 1'b0;
    chk("refill_empty", 32'(count), 32'd0);

    // -inf then -0
    in_valid = 1'b1;
    in_sum   = 32'hFF80_0000;
    tick();
    in_sum   = 32'h8000_0000;
    tick();
    in_valid = 1'b0;
    chk("ninf_data",   out_data,          32'hFF80_0000);
    chk("ninf_flags",  32'(out_flags),    32'b0101);
    chk("sticky_011",  32'(sticky_flags), 32'b011);
    out_ready = 1'b1;
    tick();
    chk("nzero_data",  out_data,       32'h8000_0000);
    chk("nzero_flags", 32'(out_flags), 32'b0011);
    tick();
    out_ready = 1'b0;
    chk("class_empty", 32'(count), 32'd0);

    // flag_clr alone clears
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    chk("clr_no_push", 32'(sticky_flags), 32'd0);

    // +inf sets sticky 010
    in_valid = 1'b1;
    in_sum   = 32'h7F80_0000;
    tick();
    in_valid = 1'b0;
    chk("pinf_sticky", 32'(sticky_flags), 32'b010);
    chk("pinf_flags",  32'(out_flags),    32'b0100);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // NaN push together with flag_clr: only nan remains
    in_valid = 1'b1;
    in_sum   = 32'h7F80_0001;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    in_sum   = 32'hFFC0_0001;
    chk("nan_clr_sticky", 32'(sticky_flags), 32'b100);
    chk("nan1_data",      out_data,          NAN1_EXP);
    chk("nan1_flags",     32'(out_flags),    32'b1000);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("nan2_data",  out_data,       NAN2_EXP);
    chk("nan2_flags", 32'(out_flags), 32'(NAN2_FLG));
    tick();
    out_ready = 1'b0;
    chk("nan_empty", 32'(count), 32'd0);

    // Prime two entries, then stream push+pop for 10 cycles
    q.delete();
    in_valid = 1'b1;
    in_sum   = 32'h3F00_0000;
    q.push_back(in_sum);
    tick();
    in_sum   = 32'h3E80_0000;
    q.push_back(in_sum);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stream_count", 32'(count), 32'd2);
      chk("stream_data",  out_data,   q[0]);
      in_sum = 32'h4100_0000 + 32'(i);
      q.push_back(in_sum);
      tick();
      void'(q.pop_front());
    end
    chk("stream_count_end", 32'(count),        32'd2);
    chk("stream_data_end",  out_data,          q[0]);
    chk("stream_sticky",    32'(sticky_flags), 32'b100);

    // Reset mid-stream with push, pop and flag_clr all active
    flag_clr = 1'b1;
    rst      = 1'b1;
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    chk("midrst_count",    32'(count),        32'd0);
    chk("midrst_valid",    32'(out_valid),    32'd0);
    chk("midrst_data",     out_data,          32'h0);
    chk("midrst_in_ready", 32'(in_ready),     32'd1);
    chk("midrst_sticky",   32'(sticky_flags), 32'd0);
    tick();
    chk("midrst_count_hold", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
